// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data memory responder.
package dmem_pkg;

    localparam int DMEM_AW    = 6;
    localparam int DMEM_DEPTH = 1 << DMEM_AW;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAITST = 2'd1,
        ACK    = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_if.sv
// Initiator <-> data memory request/response bundle.
interface dmem_if #(
    parameter int AW = dmem_pkg::DMEM_AW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          ack;
    logic [31:0]   rdata;
    logic          busy;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata, busy
    );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
// Latency: write lands and read data registers on the edge that samples the enable.
// Backpressure: none; the controller issues at most one access per request.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int AW    = DMEM_AW,
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wr_dat,
    input  logic [3:0]    wr_be,
    output logic [31:0]   rd_dat
);

    logic [31:0] mem [DEPTH];

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[addr][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_dat <= 32'h0;
        end else if (rd_en) begin
            rd_dat <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data memory responder with programmable wait states.
// Latency: req accepted at edge N gives ack in the cycle after edge N+WAIT+1.
// Backpressure: busy high from acceptance through ack; req is ignored while busy.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int AW    = DMEM_AW,
    parameter int DEPTH = DMEM_DEPTH,
    parameter int WAIT  = 2
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               mem_go;
    logic               accept;

    logic               lat_we;
    logic [AW-1:0]      lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_be;

    logic               wr_en;
    logic               rd_en;
    logic [31:0]        rd_dat;

    assign accept = (state == IDLE) && bus.req;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_go    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_nxt = WAITST;
                    cnt_nxt   = CNT_W'(WAIT);
                end
            end
            WAITST: begin
                // Counter drains to zero, then one more edge performs the access.
                if (cnt == '0) begin
                    state_nxt = ACK;
                    mem_go    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_be    <= bus.be;
        end
    end

    // Gating with reset drops a pending access that reset abandons.
    assign wr_en = mem_go && lat_we && !reset;
    assign rd_en = mem_go && !lat_we && !reset;

    dmem_array #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (lat_addr),
        .wr_dat (lat_wdata),
        .wr_be  (lat_be),
        .rd_dat (rd_dat)
    );

    assign bus.ack   = (state == ACK);
    assign bus.busy  = (state != IDLE);
    assign bus.rdata = rd_dat;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: a WAIT=2 instance and a WAIT=0 instance, with a read-data scoreboard.
module tb_dmem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    dmem_if #(.AW(6)) a_if ();
    dmem_if #(.AW(6)) b_if ();

    dmem_resp #(.AW(6), .DEPTH(64), .WAIT(2)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if)
    );

    dmem_resp #(.AW(6), .DEPTH(64), .WAIT(0)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_a [64];
    logic [31:0] model_b [64];
    logic [31:0] last_rd [2];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rq, input logic we, input logic [5:0] ad,
                         input logic [31:0] wd, input logic [3:0] be);
        if (sel == 0) begin
            a_if.req = rq; a_if.we = we; a_if.addr = ad; a_if.wdata = wd; a_if.be = be;
        end else begin
            b_if.req = rq; b_if.we = we; b_if.addr = ad; b_if.wdata = wd; b_if.be = be;
        end
    endtask

    function automatic logic obs_ack(input int sel);
        return (sel == 0) ? a_if.ack : b_if.ack;
    endfunction

    function automatic logic obs_busy(input int sel);
        return (sel == 0) ? a_if.busy : b_if.busy;
    endfunction

    function automatic logic [31:0] obs_rdata(input int sel);
        return (sel == 0) ? a_if.rdata : b_if.rdata;
    endfunction

    function automatic logic [31:0] model_rd(input int sel, input logic [5:0] ad);
        return (sel == 0) ? model_a[ad] : model_b[ad];
    endfunction

    // One complete request: drive, scramble inputs after acceptance, check latency and data.
    task automatic txn(input int sel, input logic we, input logic [5:0] ad,
                       input logic [31:0] wd, input logic [3:0] be, input string tag);
        int          waitn;
        int          e;
        logic [31:0] m;
        logic [31:0] exp;
        waitn = (sel == 0) ? 2 : 0;
        @(negedge clk);
        drive(sel, 1'b1, we, ad, wd, be);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, ~we, ad + 6'd1, ~wd, ~be);
        if (we) begin
            m = model_rd(sel, ad);
            for (int i = 0; i < 4; i++) begin
                if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
            end
            if (sel == 0) model_a[ad] = m; else model_b[ad] = m;
        end else begin
            exp_q.push_back(model_rd(sel, ad));
        end
        check({tag, "_busy_acc"}, 32'(obs_busy(sel)), 32'd1);
        e = 0;
        while (obs_ack(sel) !== 1'b1 && e < 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        check({tag, "_latency"}, 32'(e), 32'(waitn + 1));
        if (!we) begin
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check({tag, "_rdata"}, obs_rdata(sel), exp);
                last_rd[sel] = exp;
            end
        end else begin
            check({tag, "_rdata_hold"}, obs_rdata(sel), last_rd[sel]);
        end
        @(posedge clk);
        #1;
        check({tag, "_ack_drop"}, 32'(obs_ack(sel)), 32'd0);
        check({tag, "_busy_drop"}, 32'(obs_busy(sel)), 32'd0);
    endtask

    initial begin
        logic [5:0]  ad;
        logic [31:0] exp;

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);

        // Reset with a simultaneous request: reset wins, nothing accepted.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 6'd1, 32'hFFFF_FFFF, 4'hF);
        drive(1, 1'b1, 1'b0, 6'd1, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk);
        #1;
        check("rst_ack_a", 32'(a_if.ack), 32'd0);
        check("rst_busy_a", 32'(a_if.busy), 32'd0);
        check("rst_rdata_a", a_if.rdata, 32'h0);
        check("rst_ack_b", 32'(b_if.ack), 32'd0);
        check("rst_busy_b", 32'(b_if.busy), 32'd0);
        check("rst_rdata_b", b_if.rdata, 32'h0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check("post_rst_busy_a", 32'(a_if.busy), 32'd0);
        check("post_rst_busy_b", 32'(b_if.busy), 32'd0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;

        // Basic write/read with two wait states.
        txn(0, 1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF, "wr5");
        txn(0, 1'b0, 6'd5, 32'h0, 4'h0, "rd5");

        // Byte lanes and an all-disabled write.
        txn(0, 1'b1, 6'd9, 32'h1122_3344, 4'hF, "pre9");
        txn(0, 1'b1, 6'd9, 32'hAABB_CCDD, 4'b0101, "lane9");
        txn(0, 1'b0, 6'd9, 32'h0, 4'h0, "rd9_lane");
        txn(0, 1'b1, 6'd9, 32'h5566_7788, 4'b0000, "be0_9");
        txn(0, 1'b0, 6'd9, 32'h0, 4'h0, "rd9_be0");

        // Busy guard: req held high with a different address every cycle.
        for (int i = 16; i < 24; i++) begin
            txn(0, 1'b1, 6'(i), 32'hA500_0000 | 32'(i * 7), 4'hF, "preload");
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ad = 6'(16 + $urandom_range(0, 7));
            drive(0, 1'b1, 1'b0, ad, $urandom, 4'hF);
            @(posedge clk);
            if (i % 5 == 0) exp_q.push_back(model_a[ad]);
            #1;
            check("guard_ack", 32'(a_if.ack), 32'(i % 5 == 3));
            if (a_if.ack === 1'b1 && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("guard_rdata", a_if.rdata, exp);
                last_rd[0] = exp;
            end
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        check("guard_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Reset during WAITST abandons the write.
        txn(0, 1'b1, 6'd3, 32'h0, 4'hF, "zero3");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 6'd3, 32'h1234_5678, 4'hF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ack", 32'(a_if.ack), 32'd0);
        check("midrst_busy", 32'(a_if.busy), 32'd0);
        check("midrst_rdata", a_if.rdata, 32'h0);
        last_rd[0] = 32'h0;
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_ack", 32'(a_if.ack), 32'd0);
        end
        txn(0, 1'b0, 6'd3, 32'h0, 4'h0, "rd3_after_rst");

        // Zero wait states, top address.
        txn(1, 1'b1, 6'd63, 32'hCAFE_F00D, 4'hF, "w0_wr63");
        txn(1, 1'b1, 6'd62, 32'h0BAD_F00D, 4'hF, "w0_wr62");
        txn(1, 1'b0, 6'd63, 32'h0, 4'h0, "w0_rd63");
        txn(1, 1'b1, 6'd63, 32'h7700_0000, 4'b1000, "w0_lane63");
        txn(1, 1'b0, 6'd63, 32'h0, 4'h0, "w0_rd63b");
        txn(1, 1'b0, 6'd62, 32'h0, 4'h0, "w0_rd62");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
